// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. It serialises instruction-fetch and load/store
// requests onto a single-ported word memory, with one transaction in flight
// at a time. Each response is routed back to the port that issued it. A
// transaction whose response never arrives is closed with an error response.
module mem_arbiter #(
  parameter bit          RR      = 1'b1,  // 1: round-robin, 0: data port always wins
  parameter int unsigned TIMEOUT = 16     // WAIT cycles before forcing an error (2..255)
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port (read-only)
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // load/store port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        err,
  // memory side
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_addr_ready,
  input  logic        mem_data_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        owner_q, owner_d;       // 1 = data port owns the transaction
  logic        prefer_if_q, prefer_if_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        can_grant, pick_d, resp;
  logic [31:0] resp_data;

  // The request registers drive the memory bus directly. Write enable and
  // request valid are qualified by ISSUE because the memory writes on any
  // edge where write is high.
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign mem_addr_ready = (state_q == S_ISSUE);
  assign mem_write      = (state_q == S_ISSUE) && write_q;

  // Next state, arbitration, response routing and timeout counting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    owner_d     = owner_q;
    prefer_if_d = prefer_if_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    err         = 1'b0;
    if_rdata    = if_rdata_q;
    d_rdata     = d_rdata_q;
    can_grant   = 1'b0;
    pick_d      = 1'b0;
    resp        = 1'b0;
    resp_data   = '0;

    case (state_q)
      S_IDLE: can_grant = 1'b1;
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (mem_data_ready) begin
          resp      = 1'b1;
          resp_data = mem_rdata;
          can_grant = 1'b1;   // back-to-back: hand the bus over in the same cycle
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp      = 1'b1;
          resp_data = ERR_DATA;
          err       = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The owner sees the response combinationally; the other port keeps the
    // value it was last given.
    if (resp) begin
      if (owner_q) begin
        d_rvalid  = 1'b1;
        d_rdata   = resp_data;
        d_rdata_d = resp_data;
      end else begin
        if_rvalid  = 1'b1;
        if_rdata   = resp_data;
        if_rdata_d = resp_data;
      end
    end

    if (can_grant && (if_req || d_req)) begin
      pick_d      = d_req && (!if_req || !RR || !prefer_if_q);
      prefer_if_d = pick_d;
      owner_d     = pick_d;
      state_d     = S_ISSUE;
      if (pick_d) begin
        d_gnt   = 1'b1;
        addr_d  = d_addr;
        write_d = d_write;
        wdata_d = d_wdata;
        wstrb_d = d_wstrb;
      end else begin
        if_gnt  = 1'b1;
        addr_d  = if_addr;
        write_d = 1'b0;
        wdata_d = '0;
        wstrb_d = '0;
      end
    end
  end

  // State and request registers. Reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      owner_q     <= 1'b0;
      prefer_if_q <= 1'b1;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      owner_q     <= owner_d;
      prefer_if_q <= prefer_if_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-ported word memory (mem_addr_ready / mem_data_ready handshake, byte write strobes) between the core's instruction-fetch port (read-only) and its load/store port.
- Sits between rv and mem.
- Serialises requests with one transaction outstanding and round-robin or fixed priority.
- Routes each response back to the issuing port and reports a response timeout.

Parameters:
- RR, 1: 1 = round-robin on contention; 0 = fixed priority, data port wins.
- TIMEOUT, 16: cycles to wait in WAIT for mem_data_ready before forcing an error response; range 2..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted (1-cycle pulse).
- if_rvalid  out  1  fetch response valid (1-cycle pulse).
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_addr  in  32  data byte address.
- d_write  in  1  1 = store.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte strobes.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response valid; pulses for stores too.
- d_rdata  out  32  load data.
- err  out  1  pulses with the rvalid of a timed-out transaction.
- mem_addr  out  32  memory address.
- mem_write  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory strobes.
- mem_addr_ready  out  1  request valid to memory.
- mem_data_ready  in  1  memory response valid.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset values: state IDLE; mem_addr_ready=0, mem_write=0, mem_wstrb=0, mem_addr=0, mem_wdata=0; all gnt/rvalid/err = 0; RR pointer favours fetch; timeout counter = 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high, grant a winner: pulse its gnt this cycle (combinational from req and state).
  - On the clock edge, latch addr, write, wdata and wstrb (zeroed for fetch), plus the owner, into registers; go to ISSUE.
  - With no req, stay in IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, RR=1: the port not granted last wins; the pointer updates on every grant.
  - Both requesting, RR=0: the data port always wins.
- ISSUE (exactly 1 cycle):
  - mem_addr_ready=1; mem_addr, mem_wdata and mem_wstrb come from registers.
  - mem_write = latched write.
  - Go to WAIT; clear the timeout counter.
- Outside ISSUE: mem_write=0 and mem_addr_ready=0. Required because mem writes on any edge with write high.
- WAIT:
  - On mem_data_ready=1, pulse the owner's rvalid the same cycle. Owner rdata = mem_rdata (combinational passthrough); the non-owner rdata holds its last value.
  - If a req is pending that same cycle, grant it immediately (gnt pulse in this cycle) and go to ISSUE. This allows back-to-back requests, one every 2 cycles. Otherwise go to IDLE.
  - If mem_data_ready is absent, the counter increments. When counter == TIMEOUT-1, pulse the owner's rvalid with err=1 and rdata=32'hDEADBEEF, then go to IDLE.
- Nominal latency: req seen cycle 0 (gnt), ISSUE cycle 1, rvalid cycle 2.
- mem_data_ready outside WAIT (stray, e.g. a response in flight across a reset) is ignored: no rvalid.
- A port's req dropped before gnt is legal; nothing is issued for it.
- Reset mid-transaction: immediate return to IDLE; the in-flight response is dropped; no rvalid is generated for it.
- mem_addr is passed unmodified (byte address); mem does the word indexing.

Test Plan:
- Fetch only: if_req at cycle 0, addr 0x10, mem word 0x00000013 -> if_gnt at cycle 0, mem_addr_ready at cycle 1 with mem_write=0 and mem_addr=0x10, if_rvalid at cycle 2 with if_rdata=0x00000013; err=0.
- Store then load: d_write=1, addr 0x20, wdata 0xAABBCCDD, wstrb 4'b0011 on word 0x11223344; then a load of 0x20 -> d_rdata=0x1122CCDD. mem_write is high for exactly 1 cycle.
- Contention, RR=1: if_req and d_req held for 4 grants -> grant order IF, D, IF, D; responses routed to the matching port; back-to-back issue every 2 cycles.
- Contention, RR=0: both requests held -> d_gnt on every grant until d_req drops, then if_gnt.
- Timeout, TIMEOUT=4: memory never asserts mem_data_ready -> owner rvalid with err=1 and rdata=0xDEADBEEF, 4 cycles after ISSUE; next request serviced normally.
- Reset asserted in WAIT: outputs go to reset values asynchronously; the following mem_data_ready pulse produces no rvalid; a new fetch after reset completes in 2 cycles.
